// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: read-owner and starvation-FSM encodings.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_X    = 2'd2
  } owner_e;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_X = 1'b1
  } arb_state_e;

  localparam int STARVE_MAX_DEF = 4;

  // True when one more denied cycle brings the wait count up to the limit.
  function automatic logic starve_hit(input logic [3:0] cnt, input int max);
    logic [4:0] lim;
    lim = 5'(max);
    return ({1'b0, cnt} + 5'd1) == lim;
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard: counts consecutive denied external requests and forces one
// external grant cycle once the count reaches STARVE_MAX.
module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic x_req,
  input  logic x_gnt,
  output logic force_x
);

  arb_state_e state, state_nxt;
  logic [3:0] wait_cnt, cnt_nxt;
  logic       denied;

  assign denied = x_req & ~x_gnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (denied) cnt_nxt = wait_cnt + 4'd1;
    case (state)
      NORMAL:  if (denied && starve_hit(wait_cnt, STARVE_MAX)) state_nxt = FORCE_X;
      FORCE_X: state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  assign force_x = (state == FORCE_X);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the MEM stage (default priority) and an
// external loader/debug port. Define ARB_STATS_EN to add the stat_conflicts counter.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_stall,
  output logic [DW-1:0] p_rdata,
  output logic          p_rvalid,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic [DW-1:0] x_rdata,
  output logic          x_rvalid,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_conflicts
`endif
);

  logic   force_x;
  logic   pipe_gnt;
  owner_e rd_owner;

  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .clr     (clr),
    .x_req   (x_req),
    .x_gnt   (x_gnt),
    .force_x (force_x)
  );

  // Grants are suppressed while clr is held so nothing reaches the RAM during reset.
  always_comb begin
    x_gnt    = 1'b0;
    pipe_gnt = 1'b0;
    if (!clr) begin
      if (force_x) begin
        x_gnt    = x_req;
        pipe_gnt = p_req & ~x_req;
      end else begin
        pipe_gnt = p_req;
        x_gnt    = ~p_req & x_req;
      end
    end
  end

  assign p_stall  = p_req & ~pipe_gnt & ~clr;

  // Idle cycles leave the p_* values on the RAM bus with we low.
  assign ram_we   = x_gnt ? x_we    : (pipe_gnt & p_we);
  assign ram_addr = x_gnt ? x_addr  : p_addr;
  assign ram_din  = x_gnt ? x_wdata : p_wdata;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                   rd_owner <= OWN_NONE;
    else if (x_gnt && !x_we)   rd_owner <= OWN_X;
    else if (pipe_gnt && !p_we) rd_owner <= OWN_PIPE;
    else                       rd_owner <= OWN_NONE;
  end

  assign p_rvalid = (rd_owner == OWN_PIPE);
  assign x_rvalid = (rd_owner == OWN_X);
  assign p_rdata  = ram_dout;
  assign x_rdata  = ram_dout;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                          stat_conflicts <= '0;
    else if (p_req && x_req && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural arbitration/RAM model checked every cycle.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          p_req, p_we, x_req, x_we;
  logic [AW-1:0] p_addr, x_addr, ram_addr;
  logic [DW-1:0] p_wdata, x_wdata, p_rdata, x_rdata, ram_din, ram_dout;
  logic          p_stall, p_rvalid, x_gnt, x_rvalid, ram_we;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_conflicts;
`endif

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.STARVE_MAX(SM), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .clr(clr),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rdata(x_rdata), .x_rvalid(x_rvalid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef ARB_STATS_EN
    , .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency; address 0x10 is preloaded during reset.
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (clr) ram_mem[8'h10] <= 32'hDEADBEEF;
    else if (ram_we) ram_mem[ram_addr[7:0]] <= ram_din;
    ram_dout <= ram_mem[ram_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: an external request waiting SM denied cycles wins the next cycle;
  // otherwise the pipe wins whenever it asks. Reads return from a golden memory.
  logic [DW-1:0] gold [256];
  initial begin
    int       denied;
    int       pend;        // 0 none, 1 pipe, 2 external
    logic [DW-1:0] pend_data;
    int       conf;
    logic     ex, ep;
    logic [AW-1:0] ga;
    denied = 0; pend = 0; pend_data = '0; conf = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        denied = 0; pend = 0; conf = 0;
        gold[8'h10] = 32'hDEADBEEF;
        chk("m_rst_pstall", {31'b0, p_stall}, 0);
        chk("m_rst_xgnt",   {31'b0, x_gnt}, 0);
        chk("m_rst_ramwe",  {31'b0, ram_we}, 0);
        chk("m_rst_rvalid", {30'b0, p_rvalid, x_rvalid}, 0);
`ifdef ARB_STATS_EN
        chk("m_rst_stat", {16'b0, stat_conflicts}, 0);
`endif
      end else begin
        ex = x_req && (!p_req || denied >= SM);
        ep = p_req && !ex;
        chk("m_xgnt",   {31'b0, x_gnt}, {31'b0, ex});
        chk("m_pstall", {31'b0, p_stall}, {31'b0, p_req && !ep});
        chk("m_ramwe",  {31'b0, ram_we}, {31'b0, ex ? x_we : (ep && p_we)});
        if (ex || ep) begin
          ga = ex ? x_addr : p_addr;
          chk("m_ramaddr", ram_addr, ga);
          if (ex ? x_we : p_we) chk("m_ramdin", ram_din, ex ? x_wdata : p_wdata);
        end
        chk("m_prvalid", {31'b0, p_rvalid}, {31'b0, pend == 1});
        chk("m_xrvalid", {31'b0, x_rvalid}, {31'b0, pend == 2});
        if (pend == 1) chk("m_prdata", p_rdata, pend_data);
        if (pend == 2) chk("m_xrdata", x_rdata, pend_data);
`ifdef ARB_STATS_EN
        chk("m_stat", {16'b0, stat_conflicts}, conf);
        if (p_req && x_req && conf < 65535) conf++;
`endif
        pend = 0;
        if (ex) begin
          if (x_we) gold[x_addr[7:0]] = x_wdata;
          else begin pend = 2; pend_data = gold[x_addr[7:0]]; end
        end else if (ep) begin
          if (p_we) gold[p_addr[7:0]] = p_wdata;
          else begin pend = 1; pend_data = gold[p_addr[7:0]]; end
        end
        denied = (x_req && !ex) ? denied + 1 : 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] g, s;
    clr = 1'b1;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
    repeat (2) tick;
    // Requests during reset must not be granted.
    p_req = 1; x_req = 1; #1;
    chk("rst_pstall", {31'b0, p_stall}, 0);
    chk("rst_xgnt",   {31'b0, x_gnt}, 0);
    chk("rst_ramwe",  {31'b0, ram_we}, 0);
    chk("rst_wcnt",   {28'b0, u_dut.u_starve.wait_cnt}, 0);
    tick; p_req = 0; x_req = 0; clr = 0;

    // Pipe load of 0x10.
    tick; p_req = 1; p_we = 0; p_addr = 32'h10; #1;
    chk("ld_addr",  ram_addr, 32'h10);
    chk("ld_stall", {31'b0, p_stall}, 0);
    tick; p_req = 0; #1;
    chk("ld_rvalid", {31'b0, p_rvalid}, 1);
    chk("ld_rdata",  p_rdata, 32'hDEADBEEF);
    chk("ld_xrvalid", {31'b0, x_rvalid}, 0);

    // External write while pipe idle, then pipe reads it back.
    tick; x_req = 1; x_we = 1; x_addr = 32'h20; x_wdata = 32'h1234; #1;
    chk("xw_gnt", {31'b0, x_gnt}, 1);
    chk("xw_we",  {31'b0, ram_we}, 1);
    chk("xw_din", ram_din, 32'h1234);
    tick; x_req = 0; x_we = 0; p_req = 1; p_addr = 32'h20;
    tick; p_req = 0; #1;
    chk("xw_readback", p_rdata, 32'h1234);

    // External read.
    tick; x_req = 1; x_addr = 32'h10;
    tick; x_req = 0; #1;
    chk("xr_rvalid", {31'b0, x_rvalid}, 1);
    chk("xr_rdata",  x_rdata, 32'hDEADBEEF);
    chk("xr_prvalid", {31'b0, p_rvalid}, 0);

    // Back-to-back pipe store then loads.
    tick; p_req = 1; p_we = 1; p_addr = 32'h30; p_wdata = 32'h55;
    tick; p_we = 0;
    tick; p_addr = 32'h10; #1;
    chk("b2b_st", p_rdata, 32'h55);
    tick; p_req = 0; #1;
    chk("b2b_ld", p_rdata, 32'hDEADBEEF);

    // Starvation: both requesting continuously.
    tick; p_req = 1; p_we = 0; p_addr = 32'h20; x_req = 1; x_we = 0; x_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      #1; g[i] = x_gnt; s[i] = p_stall;
      tick;
    end
    chk("starve_xgnt",  {22'b0, g}, 32'h210);
    chk("starve_stall", {22'b0, s}, 32'h210);

    // Withdraw on the forced cycle.
    repeat (4) tick;
    x_req = 0; #1;
    chk("wd_force", {31'b0, u_dut.force_x}, 1);
    chk("wd_stall", {31'b0, p_stall}, 0);
    chk("wd_xgnt",  {31'b0, x_gnt}, 0);
    tick; p_req = 0; #1;
    chk("wd_state", {31'b0, u_dut.u_starve.state == NORMAL}, 1);
    chk("wd_wcnt",  {28'b0, u_dut.u_starve.wait_cnt}, 0);

    // Reset while a pipe load is in flight.
    tick; p_req = 1; p_addr = 32'h10;
    tick; p_req = 0; clr = 1; #1;
    chk("rr_rvalid", {31'b0, p_rvalid}, 0);
    chk("rr_wcnt",   {28'b0, u_dut.u_starve.wait_cnt}, 0);
    chk("rr_state",  {31'b0, u_dut.u_starve.state == NORMAL}, 1);
    tick; clr = 0;
    tick; #1;
    chk("rr_after", {31'b0, p_rvalid}, 0);

    // Ten conflict cycles.
    tick; p_req = 1; x_req = 1; p_addr = 32'h20; x_addr = 32'h10;
    repeat (10) tick;
    p_req = 0; x_req = 0;
`ifdef ARB_STATS_EN
    #1 chk("stat_10", {16'b0, stat_conflicts}, 10);
`endif
    repeat (3) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
